io_bus_arbiter: RTL and testbench



---
 rtl/io_bus_arbiter.sv | 133 +++++++++++++
 tb/tb_io_bus_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: two-master arbiter/sequencer for the shared data-memory/IO
// port (RAM, switch input at addr[6], LED register at addr[7]).
// Master 0 = CPU load/store unit, master 1 = program-loader/debug port.
// One winning request is latched in IDLE, driven to the port for exactly one
// ACCESS cycle, then answered in RESP with registered rdata and a done pulse.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   m0_req/op/addr/we/wdata  master 0 request set, m0_done completion pulse
//   m1_req/op/addr/we/wdata  master 1 request set, m1_done completion pulse
//   rdata                    registered read data, held until next RESP
//   mem_op/addr/we/wdata     access driven to the port
//   mem_rdata                combinational read data from the port
//   busy                     high while a transaction is in flight
//
// Build option: define ARB_RR_EN for round-robin tie-break; otherwise
// master 0 always wins a tie (fixed priority).

module io_bus_arbiter #(
    parameter int AW  = 8,
    parameter int DW  = 32,
    parameter int OPW = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           m0_req,
    input  logic [OPW-1:0] m0_op,
    input  logic [AW-1:0]  m0_addr,
    input  logic           m0_we,
    input  logic [DW-1:0]  m0_wdata,
    output logic           m0_done,
    input  logic           m1_req,
    input  logic [OPW-1:0] m1_op,
    input  logic [AW-1:0]  m1_addr,
    input  logic           m1_we,
    input  logic [DW-1:0]  m1_wdata,
    output logic           m1_done,
    output logic [DW-1:0]  rdata,
    output logic [OPW-1:0] mem_op,
    output logic [AW-1:0]  mem_addr,
    output logic           mem_we,
    output logic [DW-1:0]  mem_wdata,
    input  logic [DW-1:0]  mem_rdata,
    output logic           busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic grant;
    logic winner;
    logic owner;
    logic we_q;

`ifdef ARB_RR_EN
    logic last_grant;
`endif

    // Next-state and arbitration. Requests are only looked at in IDLE.
    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        winner    = 1'b0;
        case (state)
            IDLE: begin
                if (m0_req || m1_req) begin
                    grant     = 1'b1;
                    state_nxt = ACCESS;
`ifdef ARB_RR_EN
                    // On a tie the master that did not win last time goes.
                    if (m0_req && m1_req)
                        winner = ~last_grant;
                    else
                        winner = m1_req;
`else
                    winner = ~m0_req;
`endif
                end
            end
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= 1'b0;
            we_q      <= 1'b0;
            mem_op    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata     <= '0;
            m0_done   <= 1'b0;
            m1_done   <= 1'b0;
`ifdef ARB_RR_EN
            last_grant <= 1'b1;
`endif
        end else begin
            state   <= state_nxt;
            m0_done <= 1'b0;
            m1_done <= 1'b0;
            if (grant) begin
                owner     <= winner;
                we_q      <= winner ? m1_we    : m0_we;
                mem_op    <= winner ? m1_op    : m0_op;
                mem_addr  <= winner ? m1_addr  : m0_addr;
                mem_wdata <= winner ? m1_wdata : m0_wdata;
`ifdef ARB_RR_EN
                last_grant <= winner;
`endif
            end
            if (state == ACCESS) begin
                // Read data is captured for writes too; harmless and simple.
                rdata   <= mem_rdata;
                m0_done <= ~owner;
                m1_done <= owner;
            end
        end
    end

    // Decoded from the state register so a reset kills the write at once.
    assign mem_we = (state == ACCESS) && we_q;
    assign busy   = (state != IDLE);

endmodule

// File: tb/tb_io_bus_arbiter.sv
// tb_io_bus_arbiter: self-checking bench for io_bus_arbiter.
// Table vectors, hand sequences and random traffic against a schedule model.

module tb_io_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m1_req, m0_we, m1_we;
    logic [2:0]  m0_op, m1_op;
    logic [7:0]  m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic        m0_done, m1_done;
    logic [31:0] rdata;
    logic [2:0]  mem_op;
    logic [7:0]  mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    io_bus_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_op(m0_op), .m0_addr(m0_addr),
        .m0_we(m0_we), .m0_wdata(m0_wdata), .m0_done(m0_done),
        .m1_req(m1_req), .m1_op(m1_op), .m1_addr(m1_addr),
        .m1_we(m1_we), .m1_wdata(m1_wdata), .m1_done(m1_done),
        .rdata(rdata), .mem_op(mem_op), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    // Schedule model: a transaction granted at edge number ms occupies the
    // port in the cycle after ms (phase 0) and answers in the next (phase 1).
    // A new grant needs the port idle before the edge: e - ms >= 3.
    int          e;
    int          ms;
    bit          mown, mwe, lg;
    logic [7:0]  maddr;
    logic [2:0]  mop;
    logic [31:0] mwd, mrd;

    task automatic model_reset();
        e = 0; ms = -100; mown = 0; mwe = 0; lg = 1;
        maddr = 0; mop = 0; mwd = 0; mrd = 0;
    endtask

    task automatic model_edge();
        bit w;
        if (rst) begin
            model_reset();
            return;
        end
        e++;
        if (e - ms == 1) mrd = mem_rdata;
        if (e - ms >= 3 && (m0_req || m1_req)) begin
            if (m0_req && m1_req) begin
`ifdef ARB_RR_EN
                w = !lg;
`else
                w = 0;
`endif
            end else begin
                w = m1_req;
            end
            ms = e; mown = w; lg = w;
            mwe   = w ? m1_we    : m0_we;
            maddr = w ? m1_addr  : m0_addr;
            mop   = w ? m1_op    : m0_op;
            mwd   = w ? m1_wdata : m0_wdata;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_all();
        int p;
        p = e - ms;
        chk("busy", 32'(busy), 32'(p < 2));
        chk("mem_we", 32'(mem_we), 32'(p == 0 && mwe));
        chk("m0_done", 32'(m0_done), 32'(p == 1 && !mown));
        chk("m1_done", 32'(m1_done), 32'(p == 1 && mown));
        chk("rdata", rdata, mrd);
        chk("mem_addr", 32'(mem_addr), 32'(maddr));
        chk("mem_op", 32'(mem_op), 32'(mop));
        chk("mem_wdata", mem_wdata, mwd);
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle_inputs();
        m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0;
        m0_op = 0; m1_op = 0; m0_addr = 0; m1_addr = 0;
        m0_wdata = 0; m1_wdata = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        idle_inputs();
        model_reset();
        @(negedge clk);
        check_all();
        rst = 0;
    endtask

    typedef struct {
        bit          r0, r1, we;
        logic [7:0]  a0, a1;
        logic [31:0] wd, rd;
        bit          e0, e1;
        logic [7:0]  ea;
    } vec_t;

    vec_t vt[6];
    int   order[$];
    int   exp_order[4];

    initial begin
        rst = 1;
        idle_inputs();
        mem_rdata = 0;
        model_reset();

        // Table: each record is one full transaction started from IDLE.
        vt[0] = '{1, 0, 1, 8'h80, 8'h11, 32'h37, 32'hAAAA0001, 1, 0, 8'h80};
        vt[1] = '{0, 1, 0, 8'h12, 8'h40, 32'h01, 32'h00000005, 0, 1, 8'h40};
        vt[2] = '{1, 1, 0, 8'h21, 8'h22, 32'h02, 32'h12345678, 1, 0, 8'h21};
`ifdef ARB_RR_EN
        vt[3] = '{1, 1, 1, 8'h31, 8'h32, 32'h03, 32'hCAFEF00D, 0, 1, 8'h32};
        vt[4] = '{1, 0, 0, 8'h41, 8'h42, 32'h04, 32'h0BADBEEF, 1, 0, 8'h41};
        vt[5] = '{1, 1, 0, 8'h51, 8'h52, 32'h05, 32'hDEADBEEF, 0, 1, 8'h52};
        exp_order = '{0, 1, 0, 1};
`else
        vt[3] = '{1, 1, 1, 8'h31, 8'h32, 32'h03, 32'hCAFEF00D, 1, 0, 8'h31};
        vt[4] = '{1, 0, 0, 8'h41, 8'h42, 32'h04, 32'h0BADBEEF, 1, 0, 8'h41};
        vt[5] = '{1, 1, 0, 8'h51, 8'h52, 32'h05, 32'hDEADBEEF, 1, 0, 8'h51};
        exp_order = '{0, 0, 0, 0};
`endif

        do_reset();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rdata", rdata, 0);

        foreach (vt[i]) begin
            m0_req = vt[i].r0; m1_req = vt[i].r1;
            m0_we = vt[i].we; m1_we = vt[i].we;
            m0_op = 3'b111; m1_op = 3'b010;
            m0_addr = vt[i].a0; m1_addr = vt[i].a1;
            m0_wdata = vt[i].wd; m1_wdata = ~vt[i].wd;
            mem_rdata = vt[i].rd;
            step();
            step();
            chk($sformatf("vec%0d_done0", i), 32'(m0_done), 32'(vt[i].e0));
            chk($sformatf("vec%0d_done1", i), 32'(m1_done), 32'(vt[i].e1));
            chk($sformatf("vec%0d_rdata", i), rdata, vt[i].rd);
            chk($sformatf("vec%0d_addr", i), 32'(mem_addr), 32'(vt[i].ea));
            idle_inputs();
            mem_rdata = 32'hFFFF_0000;
            step();
            chk($sformatf("vec%0d_hold", i), rdata, vt[i].rd);
            step();
        end

        // Single write: one-cycle mem_we, done two cycles after request.
        m0_req = 1; m0_we = 1; m0_op = 3'b111;
        m0_addr = 8'h80; m0_wdata = 32'h37;
        step();
        chk("wr_we_access", 32'(mem_we), 1);
        chk("wr_no_done_yet", 32'(m0_done), 0);
        step();
        chk("wr_we_resp", 32'(mem_we), 0);
        chk("wr_done", 32'(m0_done), 1);
        chk("wr_no_m1", 32'(m1_done), 0);
        idle_inputs();
        step();
        chk("wr_done_pulse", 32'(m0_done), 0);

        // Request change during ACCESS has no effect on the latched access.
        m0_req = 1; m0_addr = 8'h10;
        step();
        m0_addr = 8'h20;
        chk("chg_access", 32'(mem_addr), 32'h10);
        step();
        chk("chg_resp", 32'(mem_addr), 32'h10);
        idle_inputs();
        step();

        // Reset in the middle of a write access.
        m0_req = 1; m0_we = 1; m0_addr = 8'h80;
        step();
        chk("rma_we_before", 32'(mem_we), 1);
        #2;
        rst = 1;
        #1;
        chk("rma_we_async", 32'(mem_we), 0);
        chk("rma_busy", 32'(busy), 0);
        model_reset();
        idle_inputs();
        step();
        chk("rma_no_done", 32'(m0_done | m1_done), 0);
        rst = 0;
        step();
        chk("rma_idle", 32'(busy), 0);
        chk("rma_no_done2", 32'(m0_done | m1_done), 0);

        // Tie held from reset: grant order over four transactions.
        do_reset();
        m0_req = 1; m1_req = 1;
        m0_addr = 8'h01; m1_addr = 8'h02;
        for (int c = 0; c < 12; c++) begin
            step();
            if (m0_done) order.push_back(0);
            if (m1_done) order.push_back(1);
        end
        chk("tie_count", 32'(order.size()), 4);
        for (int k = 0; k < 4 && k < order.size(); k++)
            chk($sformatf("tie_order%0d", k), 32'(order[k]), 32'(exp_order[k]));
        idle_inputs();

        // Random traffic against the schedule model.
        for (int c = 0; c < 400; c++) begin
            m0_req = ($urandom_range(0, 2) != 0);
            m1_req = ($urandom_range(0, 2) != 0);
            m0_we = 1'($urandom); m1_we = 1'($urandom);
            m0_op = 3'($urandom); m1_op = 3'($urandom);
            m0_addr = 8'($urandom); m1_addr = 8'($urandom);
            m0_wdata = $urandom; m1_wdata = $urandom;
            mem_rdata = $urandom;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
